// File: rtl/pulse_burst_decoder.sv
// Pulse-burst receiver: counts the rising edges of one burst on pulse_in and
// offers value N-1 on the dav_/rfd handshake. Define PULSE_BURST_DECODER_ERR_EN to enable err.
module pulse_burst_decoder #(
  parameter int unsigned GAP = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       rfd,
  output logic       dav_,
  output logic [1:0] numero,
  output logic       err
);

  // Handshake: the decoder is the producer. dav_ low means numero is valid and
  // stable; it stays low until the consumer drops rfd, then waits for rfd to
  // rise again before listening to the line.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    OFFER   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state;
  logic       prev;
  logic       rise;
  logic [2:0] pulse_cnt;
  logic [3:0] gap_cnt;
  logic       burst_done;
  logic [1:0] decoded;

  assign rise       = pulse_in & ~prev;
  assign burst_done = (state == COUNT) && !pulse_in && (gap_cnt == GAP_LAST);
  // Bursts longer than four pulses saturate to the largest value.
  assign decoded    = (pulse_cnt >= 3'd4) ? 2'd3 : 2'(pulse_cnt - 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= 1'b0;
      pulse_cnt <= 3'd0;
      gap_cnt   <= 4'd0;
      dav_      <= 1'b1;
      numero    <= 2'd0;
    end else begin
      prev <= pulse_in;
      case (state)
        IDLE: begin
          dav_ <= 1'b1;
          if (rise) begin
            pulse_cnt <= 3'd1;
            gap_cnt   <= 4'd0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (rise && pulse_cnt != 3'd7) begin
            pulse_cnt <= pulse_cnt + 3'd1;
          end
          if (pulse_in) begin
            gap_cnt <= 4'd0;
          end else if (burst_done) begin
            gap_cnt <= 4'd0;
            numero  <= decoded;
            dav_    <= 1'b0;
            state   <= OFFER;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        OFFER: begin
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          dav_ <= 1'b1;
          if (rfd) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          dav_  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PULSE_BURST_DECODER_ERR_EN
  // Strobe on an oversize burst and on any pulse arriving while busy offering.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (burst_done && (pulse_cnt > 3'd4)) ||
             (((state == OFFER) || (state == RELEASE)) && rise);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_burst_decoder.sv
// Bench for pulse_burst_decoder: directed scenarios plus random bursts, all
// checked every cycle against a flag-based reference of the burst protocol.
module tb_pulse_burst_decoder;

  localparam int GAP = 4;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic       rfd = 1'b1;
  logic       dav_;
  logic [1:0] numero;
  logic       err;

  always #5 clock = ~clock;

  pulse_burst_decoder #(.GAP(GAP)) dut (
    .clock    (clock),
    .reset    (reset),
    .pulse_in (pulse_in),
    .rfd      (rfd),
    .dav_     (dav_),
    .numero   (numero),
    .err      (err)
  );

`ifdef PULSE_BURST_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  bit checking = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a burst is a run of rising edges ended by GAP low samples;
  // after it, one value is offered until rfd drops and then rises again.
  bit m_prev, m_in_burst, m_offering, m_releasing;
  int m_pulses, m_lows;
  int m_dav = 1, m_num = 0, m_err = 0;

  task automatic model_update(input bit rst, input bit p, input bit r);
    bit rs;
    if (rst) begin
      m_prev = 0; m_in_burst = 0; m_offering = 0; m_releasing = 0;
      m_pulses = 0; m_lows = 0; m_dav = 1; m_num = 0; m_err = 0;
      return;
    end
    rs = p && !m_prev;
    m_err = 0;
    if (m_offering) begin
      if (rs && ERR_EN) m_err = 1;
      if (!r) begin m_offering = 0; m_releasing = 1; m_dav = 1; end
    end else if (m_releasing) begin
      if (rs && ERR_EN) m_err = 1;
      if (r) m_releasing = 0;
    end else if (m_in_burst) begin
      if (rs) m_pulses++;
      if (p) m_lows = 0;
      else begin
        m_lows++;
        if (m_lows == GAP) begin
          m_in_burst = 0; m_offering = 1; m_dav = 0;
          m_num = ((m_pulses > 4) ? 4 : m_pulses) - 1;
          if (m_pulses > 4 && ERR_EN) m_err = 1;
        end
      end
    end else if (rs) begin
      m_in_burst = 1; m_pulses = 1; m_lows = 0;
    end
    m_prev = p;
  endtask

  // scoreboard: compare every cycle, away from the active edge
  always @(negedge clock) begin
    if (checking) begin
      chk("dav_", int'(dav_), m_dav);
      chk("numero", int'(numero), m_num);
      chk("err", int'(err), m_err);
      if (err === 1'b1) err_cnt++;
    end
  end

  // driver tasks
  task automatic step(input bit p, input bit r, input bit rst);
    @(negedge clock);
    pulse_in = p; rfd = r; reset = rst;
    @(posedge clock);
    model_update(rst, p, r);
    #1;
  endtask

  // Drives n pulses of the given width, one low between them, then lows until
  // dav_ falls; lat is the number of edges from the last high sample.
  task automatic send_burst(input int n, input int width, output int lat);
    for (int i = 0; i < n; i++) begin
      if (i != 0) step(0, 1, 0);
      for (int w = 0; w < width; w++) step(1, 1, 0);
    end
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0);
      lat++;
      if (dav_ == 1'b0) return;
    end
    chk("timeout_dav_fall", 1, 0);
  endtask

  // Consumer: keep rfd high `hold` cycles, drop it until dav_ rises, raise it.
  task automatic consume(input int hold);
    for (int k = 0; k < hold; k++) step(0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      if (dav_ == 1'b1) begin
        step(0, 1, 0);
        step(0, 1, 0);
        return;
      end
    end
    chk("timeout_dav_rise", 1, 0);
  endtask

  initial begin
    int lat, e0;
    int exp_vals [4] = '{0, 1, 2, 3};

    // reset with the line toggling
    step(1, 1, 1);
    step(0, 1, 1);
    checking = 1;
    chk("reset_dav_", int'(dav_), 1);
    chk("reset_numero", int'(numero), 0);
    chk("reset_err", int'(err), 0);
    for (int k = 0; k < 6; k++) step(0, 1, 0);
    chk("reset_no_burst", int'(dav_), 1);

    // values 0..3 with exact latency
    for (int n = 1; n <= 4; n++) begin
      send_burst(n, 1, lat);
      chk($sformatf("value_%0d", n), int'(numero), exp_vals[n-1]);
      chk($sformatf("latency_%0d", n), lat, GAP);
      consume(2);
    end

    // long pulse counts once
    send_burst(1, 5, lat);
    chk("long_pulse", int'(numero), 0);
    consume(2);

    // oversize burst
    e0 = err_cnt;
    send_burst(6, 1, lat);
    chk("oversize_numero", int'(numero), 3);
    consume(1);
    chk("oversize_err", err_cnt - e0, ERR_EN ? 1 : 0);

    // handshake stall with pulses injected
    send_burst(2, 1, lat);
    e0 = err_cnt;
    for (int k = 0; k < 20; k++) step((k == 3 || k == 7) ? 1'b1 : 1'b0, 1, 0);
    chk("stall_dav_", int'(dav_), 0);
    chk("stall_numero", int'(numero), 1);
    consume(0);
    for (int k = 0; k < 10; k++) step(0, 1, 0);
    chk("stall_no_extra_offer", int'(dav_), 1);
    chk("stall_err", err_cnt - e0, ERR_EN ? 2 : 0);

    // reset mid-COUNT and mid-OFFER
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
    step(0, 1, 1);
    chk("rst_count_dav_", int'(dav_), 1);
    chk("rst_count_numero", int'(numero), 0);
    step(0, 1, 0);
    send_burst(3, 1, lat);
    step(0, 1, 1);
    chk("rst_offer_dav_", int'(dav_), 1);
    chk("rst_offer_numero", int'(numero), 0);
    step(0, 1, 0);
    send_burst(2, 1, lat);
    chk("post_reset_value", int'(numero), 1);
    consume(2);

    // random bursts, line noise during the handshake, occasional reset
    for (int b = 0; b < 40; b++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int w = $urandom_range(1, 3);
        for (int x = 0; x < w; x++) step(1, 1, 0);
        if (i != n - 1) begin
          int g = $urandom_range(1, GAP - 1);
          for (int x = 0; x < g; x++) step(0, 1, 0);
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        step(0, 1, 1);
        step(0, 1, 0);
        continue;
      end
      for (int k = 0; k < 40 && m_dav != 0; k++) step(0, 1, 0);
      chk("rand_offer", int'(dav_), 0);
      for (int k = $urandom_range(0, 5); k > 0; k--) step(1'($urandom_range(0, 1)), 1, 0);
      for (int k = 0; k < 20 && !m_releasing; k++) step(1'($urandom_range(0, 1)), 0, 0);
      for (int k = 0; k < 20 && m_releasing; k++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      step(0, 1, 0);
      step(0, 1, 0);
      if (m_in_burst) for (int k = 0; k < GAP + 1; k++) step(0, 1, 0);
      if (!m_dav[0]) consume(0);
    end

    for (int k = 0; k < 4; k++) step(0, 1, 0);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
